// File: rtl/jtkcpu_busctl.sv
// jtkcpu_busctl -- byte-wide external bus sequencer for CPU data accesses.
//
// Turns one 8-bit or 16-bit access request into one or two byte cycles on
// an 8-bit external bus. 16-bit data is big-endian: the high byte sits at
// the lower address and is transferred first. Each byte cycle waits for
// bus_ok. All state advances only on clk edges with cen=1.
//
// Ports
//   rst       in   1  asynchronous active-high reset
//   clk       in   1  system clock
//   cen       in   1  clock enable
//   req       in   1  access request, sampled only while idle
//   we        in   1  1=write, 0=read
//   wide      in   1  1=16-bit access, 0=8-bit access
//   addr      in  16  effective address
//   wdata     in  16  write data
//   mdata     out 16  assembled read data (registered)
//   busy      out  1  access in progress
//   done      out  1  one-cen-cycle completion pulse
//   bus_addr  out 16  byte address on the external bus
//   bus_dout  out  8  byte driven on writes
//   bus_din   in   8  byte returned on reads
//   bus_rd    out  1  read strobe
//   bus_wr    out  1  write strobe
//   bus_ok    in   1  bus ready; current byte completes on a cen edge with bus_ok=1

module jtkcpu_busctl (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        req,
  input  logic        we,
  input  logic        wide,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] mdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic        bus_ok
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC1 = 2'd1;
  localparam logic [1:0] ST_ACC2 = 2'd2;

  logic [1:0]  state_q,    state_d;
  logic        we_q,       we_d;
  logic        wide_q,     wide_d;
  logic [15:0] addr_q,     addr_d;
  logic [15:0] wdata_q,    wdata_d;
  logic [15:0] mdata_q,    mdata_d;
  logic        busy_q,     busy_d;
  logic        done_q,     done_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [7:0]  bus_dout_q, bus_dout_d;
  logic        bus_rd_q,   bus_rd_d;
  logic        bus_wr_q,   bus_wr_d;

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    wide_d     = wide_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mdata_d    = mdata_q;
    busy_d     = busy_q;
    done_d     = 1'b0;          // done is a single-cycle pulse
    bus_addr_d = bus_addr_q;
    bus_dout_d = bus_dout_q;
    bus_rd_d   = bus_rd_q;
    bus_wr_d   = bus_wr_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d       = we;
          wide_d     = wide;
          addr_d     = addr;
          wdata_d    = wdata;
          bus_addr_d = addr;
          bus_rd_d   = ~we;
          bus_wr_d   = we;
          // First byte out is the high byte on a 16-bit access.
          bus_dout_d = wide ? wdata[15:8] : wdata[7:0];
          busy_d     = 1'b1;
          state_d    = ST_ACC1;
        end else begin
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      ST_ACC1: begin
        if (bus_ok) begin
          if (wide_q) begin
            if (!we_q) begin
              mdata_d[15:8] = bus_din;
            end else begin
              mdata_d = mdata_q;
            end
            // 16-bit add wraps FFFF to 0000 naturally.
            bus_addr_d = addr_q + 16'd1;
            bus_dout_d = wdata_q[7:0];
            state_d    = ST_ACC2;
          end else begin
            if (!we_q) begin
              mdata_d = {8'h00, bus_din};
            end else begin
              mdata_d = mdata_q;
            end
            bus_rd_d = 1'b0;
            bus_wr_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end
        end else begin
          state_d = ST_ACC1;    // unlimited wait, everything held
        end
      end

      ST_ACC2: begin
        if (bus_ok) begin
          if (!we_q) begin
            mdata_d[7:0] = bus_din;
          end else begin
            mdata_d = mdata_q;
          end
          bus_rd_d = 1'b0;
          bus_wr_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_ACC2;
        end
      end

      default: begin
        // Unreachable encoding: recover to a quiet idle bus.
        bus_rd_d = 1'b0;
        bus_wr_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers; advance only on enabled edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      wide_q     <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      mdata_q    <= 16'h0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bus_addr_q <= 16'h0000;
      bus_dout_q <= 8'h00;
      bus_rd_q   <= 1'b0;
      bus_wr_q   <= 1'b0;
    end else if (cen) begin
      state_q    <= state_d;
      we_q       <= we_d;
      wide_q     <= wide_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mdata_q    <= mdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bus_addr_q <= bus_addr_d;
      bus_dout_q <= bus_dout_d;
      bus_rd_q   <= bus_rd_d;
      bus_wr_q   <= bus_wr_d;
    end
  end

  assign mdata    = mdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign bus_addr = bus_addr_q;
  assign bus_dout = bus_dout_q;
  assign bus_rd   = bus_rd_q;
  assign bus_wr   = bus_wr_q;

endmodule

// File: doc/jtkcpu_busctl.md
JTKCPU_BUSCTL -- requirements
Module: jtkcpu_busctl

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 clk  input  1  single system clock.
REQ-004 cen  input  1  clock enable; all state and outputs SHALL change only on clk edges with cen=1 (except reset).
REQ-005 req  input  1  access request, sampled only in IDLE.
REQ-006 we  input  1  1=write, 0=read; latched with req.
REQ-007 wide  input  1  1=16-bit access (two bytes), 0=8-bit; latched with req.
REQ-008 addr  input  16  effective address from the indexed-address unit; latched with req.
REQ-009 wdata  input  16  write data; latched with req.
REQ-010 mdata  output  16  assembled read data, registered.
REQ-011 busy  output  1  high while an access is in progress (state not IDLE).
REQ-012 done  output  1  one-cen-cycle pulse at access completion.
REQ-013 bus_addr  output  16  byte address on the external bus, registered.
REQ-014 bus_dout  output  8  byte written to the bus, registered.
REQ-015 bus_din  input  8  byte read from the bus.
REQ-016 bus_rd  output  1  read strobe.
REQ-017 bus_wr  output  1  write strobe.
REQ-018 bus_ok  input  1  bus ready; the current byte completes on a cen edge where bus_ok=1.

Function
REQ-019 States SHALL be IDLE, ACC1 and ACC2.
REQ-020 In IDLE with req=1, the block SHALL latch we, wide, addr and wdata; drive bus_addr=addr; drive bus_rd=~we and bus_wr=we; and set bus_dout=wide ? wdata[15:8] : wdata[7:0]. It SHALL then enter ACC1.
REQ-021 In ACC1 or ACC2 with bus_ok=0, the block SHALL hold state, strobes, bus_addr and bus_dout unchanged, with unlimited wait.
REQ-022 In ACC1 with bus_ok=1 and wide=1, the block SHALL capture mdata[15:8]=bus_din on a read and set bus_addr=addr+1, with 16-bit wrap so that FFFF becomes 0000.
REQ-023 In the same ACC1 transition as REQ-022, the block SHALL set bus_dout=wdata[7:0], keep the strobe asserted, and enter ACC2.
REQ-024 In ACC1 with bus_ok=1 and wide=0, the block SHALL set mdata={8'h00, bus_din} on a read, drop both strobes, pulse done, and return to IDLE.
REQ-025 In ACC2 with bus_ok=1, the block SHALL set mdata[7:0]=bus_din on a read, drop both strobes, pulse done, and return to IDLE.
REQ-026 mdata SHALL be unchanged by write accesses.
REQ-027 The data order SHALL be big-endian: the high byte is at the lower address.
REQ-028 The access SHALL take N+1 cen edges for 8-bit or N+2 for 16-bit, with bus_ok continuously high, where req is sampled at edge N. done SHALL be high for the following cen cycle.
REQ-029 req asserted outside IDLE SHALL be ignored.
REQ-030 req=1 in the cycle done=1 (state IDLE) SHALL start a new access, giving back-to-back operation with no dead cycle.
REQ-031 done SHALL clear on the next cen edge.
REQ-032 bus_rd and bus_wr SHALL never be high simultaneously.
REQ-033 With cen=0, all outputs SHALL hold, including a pending done pulse.
REQ-034 busy SHALL be 1 exactly when the state is ACC1 or ACC2.

Reset
REQ-035 rst=1 SHALL immediately force state IDLE and set bus_rd=0, bus_wr=0, busy=0, done=0, bus_addr=0000, bus_dout=00 and mdata=0000, regardless of cen.
REQ-036 Reset mid-access SHALL abort the access with no done pulse; the first request after release SHALL behave as from power-up.

Verification
REQ-037 8-bit read: addr=1234, wide=0, we=0, bus_din=A5, bus_ok=1 -> bus_rd for 1 cen cycle at 1234; mdata=00A5; done one cycle after.
REQ-038 16-bit read with wait: addr=2000, bus_din=12 then 34, bus_ok low for 3 cycles on the first byte -> bus_addr 2000 then 2001; mdata=1234; done 5 cen edges after req.
REQ-039 16-bit write across wrap: addr=FFFF, wdata=BEEF, we=1 -> bus_wr with bus_dout=BE at FFFF, then EF at 0000; bus_rd never high; mdata unchanged.
REQ-040 Back-to-back and ignored req: req held high for 6 cycles with 8-bit reads -> new access starts every 2 cen edges; req during ACC1 does not restart or alter bus_addr.
REQ-041 cen gating: cen toggling 1/0 during a 16-bit read -> same result as REQ-038, with timing counted in cen edges only and outputs frozen when cen=0.
REQ-042 Reset mid-access: rst pulse while in ACC2 of a read -> strobes drop asynchronously; no done; next read at 0010 completes normally.
